// File: rtl/issue_opcol_queue.sv
// issue_opcol_queue
//   Circular FIFO between the issue stage and the operand collector. Each
//   entry carries {SM, warp, packet, mask, live}. A flush clears the live bit
//   of every entry belonging to the flushed warp; dead entries stay counted
//   until they reach the head, where they drain at one per cycle without
//   being presented.
//
//   Optional feature (macro ISSUE_OPCOL_BYPASS_EN): when the queue is empty
//   and a push qualifies, the incoming packet is presented combinationally in
//   the same cycle. It is consumed without being written if opcolReady_i is
//   high, and is enqueued normally otherwise. With the macro undefined,
//   latency is exactly one cycle.
//
// Ports
//   clk, reset                 rising-edge clock, asynchronous active-high reset
//   issuedSM_i/Warp_i/Packet_i/Mask_i, issuedPacketValid_i   push side
//   issuedReady_o              queue can accept a push (count_o < DEPTH)
//   flush_i, flushWarp_i       squash all entries of flushWarp_i
//   opcolReady_i               consumer accepts the head entry
//   issuedSM_o/Warp_o/Packet_o/Mask_o, issuedPacketValid_o   head entry (zero when invalid)
//   count_o                    occupied entries, including squashed-but-undrained
module issue_opcol_queue #(
    parameter int unsigned PKT_W  = 128,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned WARP_W = 5,
    parameter int unsigned SM_W   = 4,
    parameter int unsigned MASK_W = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [SM_W-1:0]            issuedSM_i,
    input  logic [WARP_W-1:0]          issuedWarp_i,
    input  logic                       issuedPacketValid_i,
    input  logic [PKT_W-1:0]           issuedPacket_i,
    input  logic [MASK_W-1:0]          issuedMask_i,
    output logic                       issuedReady_o,
    input  logic                       flush_i,
    input  logic [WARP_W-1:0]          flushWarp_i,
    input  logic                       opcolReady_i,
    output logic [SM_W-1:0]            issuedSM_o,
    output logic [WARP_W-1:0]          issuedWarp_o,
    output logic                       issuedPacketValid_o,
    output logic [PKT_W-1:0]           issuedPacket_o,
    output logic [MASK_W-1:0]          issuedMask_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]  head_q, tail_q;
    logic [CNT_W-1:0]  count_q;
    logic [DEPTH-1:0]  live_q, live_d;

    // Payload storage is intentionally not reset; live_q gates visibility.
    logic [SM_W-1:0]   sm_q   [DEPTH];
    logic [WARP_W-1:0] warp_q [DEPTH];
    logic [PKT_W-1:0]  pkt_q  [DEPTH];
    logic [MASK_W-1:0] mask_q [DEPTH];

    logic ready, not_empty, push_ok, write_en, head_live, head_valid, pop;
    logic byp;

    always_comb begin
        ready     = (count_q < CNT_W'(DEPTH));
        not_empty = (count_q != '0);
        push_ok   = issuedPacketValid_i && ready
                    && !(flush_i && (flushWarp_i == issuedWarp_i));
        // Head is presentable only if live and not being squashed this cycle.
        head_live  = live_q[head_q] && !(flush_i && (flushWarp_i == warp_q[head_q]));
        head_valid = not_empty && head_live;
        // Dead heads drain regardless of opcolReady_i.
        pop        = not_empty && (opcolReady_i || !head_live);
`ifdef ISSUE_OPCOL_BYPASS_EN
        byp      = !not_empty && push_ok;
        write_en = push_ok && !(byp && opcolReady_i);
`else
        byp      = 1'b0;
        write_en = push_ok;
`endif
    end

    // Live-bit update order matters: flush clear, then pop clear, then the
    // newly written tail (never the same slot as a flushed match, since a
    // matching incoming packet is not written).
    always_comb begin
        live_d = live_q;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (flush_i && (warp_q[i] == flushWarp_i))
                live_d[i] = 1'b0;
        end
        if (pop)
            live_d[head_q] = 1'b0;
        if (write_en)
            live_d[tail_q] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            live_q  <= '0;
        end else begin
            live_q <= live_d;
            if (write_en)
                tail_q <= tail_q + PTR_W'(1);
            if (pop)
                head_q <= head_q + PTR_W'(1);
            unique case ({write_en, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (write_en) begin
            sm_q[tail_q]   <= issuedSM_i;
            warp_q[tail_q] <= issuedWarp_i;
            pkt_q[tail_q]  <= issuedPacket_i;
            mask_q[tail_q] <= issuedMask_i;
        end
    end

    always_comb begin
        issuedReady_o       = ready;
        count_o             = count_q;
        issuedPacketValid_o = 1'b0;
        issuedSM_o          = '0;
        issuedWarp_o        = '0;
        issuedPacket_o      = '0;
        issuedMask_o        = '0;
        if (byp) begin
            issuedPacketValid_o = 1'b1;
            issuedSM_o          = issuedSM_i;
            issuedWarp_o        = issuedWarp_i;
            issuedPacket_o      = issuedPacket_i;
            issuedMask_o        = issuedMask_i;
        end else if (head_valid) begin
            issuedPacketValid_o = 1'b1;
            issuedSM_o          = sm_q[head_q];
            issuedWarp_o        = warp_q[head_q];
            issuedPacket_o      = pkt_q[head_q];
            issuedMask_o        = mask_q[head_q];
        end
    end

endmodule

// File: doc/issue_opcol_queue.md
ISSUE_OPCOL_QUEUE -- requirements
Module: issue_opcol_queue

Interface
REQ-001 Parameters SHALL be (one per line: name, default, meaning):
- PKT_W, 128, issued packet width in bits
- DEPTH, 4, queue entries; power of two, 2..16
- WARP_W, 5, warp ID width
- SM_W, 4, SM ID width
- MASK_W, 32, thread active-mask width
REQ-002 Ports SHALL be (one per line: name, direction, width, meaning):
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high reset
- issuedSM_i  in  SM_W  SM ID of the incoming packet
- issuedWarp_i  in  WARP_W  warp ID of the incoming packet
- issuedPacketValid_i  in  1  push request
- issuedPacket_i  in  PKT_W  decoded instruction packet
- issuedMask_i  in  MASK_W  active mask
- issuedReady_o  out  1  queue can accept a push
- flush_i  in  1  squash request
- flushWarp_i  in  WARP_W  warp to squash
- opcolReady_i  in  1  operand collector accepts the head entry
- issuedSM_o  out  SM_W  head SM ID
- issuedWarp_o  out  WARP_W  head warp ID
- issuedPacketValid_o  out  1  head entry valid
- issuedPacket_o  out  PKT_W  head packet
- issuedMask_o  out  MASK_W  head mask
- count_o  out  $clog2(DEPTH)+1  occupied entries, including squashed-but-undrained entries

Function
REQ-003 The queue SHALL be a circular FIFO of DEPTH entries; each entry holds {SM, warp, packet, mask, live bit}.
REQ-004 issuedReady_o SHALL equal (count_o < DEPTH), decoded from registers only.
REQ-005 A push SHALL occur when issuedPacketValid_i && issuedReady_o && !(flush_i && flushWarp_i == issuedWarp_i); the entry SHALL be written at the tail with live=1.
REQ-006 A push attempted while full SHALL be ignored, with no corruption and no change to count_o.
REQ-007 An incoming packet whose warp matches an active flush_i in the same cycle SHALL be dropped.
REQ-008 On flush_i, every stored entry with warp == flushWarp_i SHALL have live cleared at the next edge; count_o SHALL be unchanged by the flush itself.
REQ-009 Head presentation SHALL be: issuedPacketValid_o = (count_o != 0) && head.live && !(flush_i && flushWarp_i == head.warp); the data outputs SHALL show the head entry when issuedPacketValid_o is 1, and zero otherwise.
REQ-010 A pop SHALL occur when (issuedPacketValid_o && opcolReady_i), or when (count_o != 0 && head is not presentable), so that squashed heads drain at one per cycle regardless of opcolReady_i.
REQ-011 A simultaneous push and pop SHALL leave count_o unchanged; a push while full SHALL remain refused even if a pop occurs in the same cycle.
REQ-012 Pointers SHALL wrap modulo DEPTH; count_o SHALL never exceed DEPTH or underflow.
REQ-013 Latency without bypass SHALL be 1 cycle: a packet pushed at edge N SHALL be presentable after edge N when it becomes the head.
REQ-014 Packet ordering SHALL be preserved; squashing SHALL never reorder live entries.

Reset
REQ-015 Asserting reset SHALL immediately, without waiting for clk, clear the pointers, count_o, and all live bits, forcing issuedPacketValid_o=0, all data outputs=0, and issuedReady_o=1.
REQ-016 Reset in mid-operation SHALL discard all stored packets; the first push after reset release SHALL land in entry 0.
REQ-017 Payload storage SHALL not need reset; no output SHALL expose stale payload while its valid is 0.

Configuration
REQ-018 When ISSUE_OPCOL_BYPASS_EN is defined, and count_o==0 with a push qualifying under REQ-005, the input SHALL drive the outputs combinationally in the same cycle.
REQ-019 Under REQ-018, if opcolReady_i=1 the packet SHALL be consumed without being written; if opcolReady_i=0 it SHALL be enqueued normally.
REQ-020 When ISSUE_OPCOL_BYPASS_EN is undefined, there SHALL be no input-to-output combinational path and latency SHALL be exactly 1 cycle.

Verification (DEPTH=4)
REQ-021 Push warps 1,2,3,4 with opcolReady_i=0 -> count_o=4, issuedReady_o=0; a 5th push of warp 5 is refused; pops then return warps 1,2,3,4 in order.
REQ-022 Queue holds warps 3,7,3,9; flush warp 3 with opcolReady_i=1 -> the squashed heads drain silently; the output sequence is 7 then 9, with count_o reaching 0 after 4 pops.
REQ-023 Full queue with simultaneous push and pop -> the push is refused and count_o goes from 4 to 3; with count_o=2, simultaneous push and pop -> count_o stays 2.
REQ-024 Push warp 6 in the same cycle as flush warp 6 -> nothing is stored and count_o is unchanged; with flushWarp_i=5 instead, the packet is stored.
REQ-025 Assert reset mid-cycle with count_o=3 -> outputs go to zero before the next clk edge; the next push occupies entry 0.
REQ-026 With bypass defined, empty queue, push of warp 2 and opcolReady_i=1 -> issuedPacketValid_o=1 with warp 2 in the same cycle and count_o stays 0; with bypass undefined -> output appears 1 cycle later.
